// File: rtl/parc_core_rob_scoreboard_pkg.sv
// Shared widths, resolve encodings and the writeback-window entry type for the
// issue-side ROB scoreboard.
package parc_core_rob_scoreboard_pkg;
  localparam int NREGS   = 32;
  localparam int REG_W   = 5;
  localparam int SLOT_W  = 4;
  localparam int MAX_LAT = 4;
  localparam int LAT_W   = $clog2(MAX_LAT);

  localparam logic [1:0] RESOLVE_KILL = 2'b01;
  localparam logic [1:0] RESOLVE_KEEP = 2'b11;

  typedef struct packed {
    logic              v;
    logic [SLOT_W-1:0] slot;
    logic [REG_W-1:0]  waddr;
  } wb_entry_t;
endpackage

// File: rtl/parc_core_wb_window.sv
// Writeback window: shifts toward stage 0 each cycle, squashes killed slots,
// then accepts one new entry at the FU-latency index.
module parc_core_wb_window
  import parc_core_rob_scoreboard_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              ins_en,
  input  logic [LAT_W-1:0]  ins_idx,
  input  logic [SLOT_W-1:0] ins_slot,
  input  logic [REG_W-1:0]  ins_waddr,
  input  logic              kill_en,
  input  logic [SLOT_W-1:0] kill_slot,
  output logic              head_v,
  output logic [SLOT_W-1:0] head_slot,
  output logic [REG_W-1:0]  head_waddr,
  output logic [MAX_LAT-1:0] occ_v
);
  wb_entry_t pipe_q [MAX_LAT];
  wb_entry_t pipe_d [MAX_LAT];

  // Order matters: shift, then kill the shifted contents, then insert.
  always_comb begin
    for (int i = 0; i < MAX_LAT-1; i++) pipe_d[i] = pipe_q[i+1];
    pipe_d[MAX_LAT-1] = '0;
    for (int i = 0; i < MAX_LAT; i++) begin
      if (kill_en && pipe_d[i].slot == kill_slot) pipe_d[i].v = 1'b0;
    end
    if (ins_en) begin
      pipe_d[ins_idx].v     = 1'b1;
      pipe_d[ins_idx].slot  = ins_slot;
      pipe_d[ins_idx].waddr = ins_waddr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MAX_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  always_comb begin
    for (int i = 0; i < MAX_LAT; i++) occ_v[i] = pipe_q[i].v;
  end

  assign head_v     = pipe_q[0].v;
  assign head_slot  = pipe_q[0].slot;
  assign head_waddr = pipe_q[0].waddr;
endmodule

// File: rtl/parc_core_rob_scoreboard.sv
// Issue-side ROB scoreboard: RAW/WAW/writeback-port/ROB-full hazard checks,
// per-register pending tags, and writeback fill generation.
module parc_core_rob_scoreboard
  import parc_core_rob_scoreboard_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              dec_val,
  input  logic              dec_src0_en,
  input  logic              dec_src1_en,
  input  logic [REG_W-1:0]  dec_src0,
  input  logic [REG_W-1:0]  dec_src1,
  input  logic              dec_dst_en,
  input  logic [REG_W-1:0]  dec_dst,
  input  logic [LAT_W-1:0]  dec_lat,
  input  logic              dec_spec,
  output logic              dec_stall,
  output logic              dec_issue,
  output logic              rob_alloc_req_val,
  input  logic              rob_alloc_req_rdy,
  output logic [REG_W-1:0]  rob_alloc_req_preg,
  output logic              rob_alloc_req_spec,
  input  logic [SLOT_W-1:0] rob_alloc_resp_slot,
  output logic              rob_fill_val,
  output logic [SLOT_W-1:0] rob_fill_slot,
  output logic [REG_W-1:0]  wb_waddr,
  input  logic [SLOT_W-1:0] rob_spec_resolve_slot,
  input  logic [1:0]        rob_spec_resolve_result,
  input  logic              rob_commit_wen,
  input  logic [SLOT_W-1:0] rob_commit_slot,
  input  logic [REG_W-1:0]  rob_commit_rf_waddr
);
  logic [NREGS-1:0]  pend_q, pend_d;
  logic [SLOT_W-1:0] tag_q [NREGS];
  logic [SLOT_W-1:0] tag_d [NREGS];
  logic [MAX_LAT-1:0] occ_v;
  logic [LAT_W:0]    lat_p1;
  logic              raw, waw, wbc, full, kill, ins_en;

  // Hazards look only at registered state; a clear landing this cycle is not
  // forwarded, so a dependent instruction waits one extra cycle.
  assign raw = (dec_src0_en && dec_src0 != '0 && pend_q[dec_src0]) ||
               (dec_src1_en && dec_src1 != '0 && pend_q[dec_src1]);
  assign waw = dec_dst_en && dec_dst != '0 && pend_q[dec_dst];
  assign lat_p1 = {1'b0, dec_lat} + (LAT_W+1)'(1);
  assign wbc = dec_dst_en && (lat_p1 < (LAT_W+1)'(MAX_LAT)) && occ_v[lat_p1[LAT_W-1:0]];
  assign full = dec_dst_en && !rob_alloc_req_rdy;

  // Allocation handshake: the slot is taken on a cycle with val && rdy, and
  // resp_slot is valid in that same cycle. val is raised whenever only the
  // ROB is blocking, so it never waits on rdy.
  assign rob_alloc_req_val  = dec_val && dec_dst_en && !(raw || waw || wbc);
  assign rob_alloc_req_preg = dec_dst;
  assign rob_alloc_req_spec = dec_spec;
  assign dec_stall = dec_val && (raw || waw || wbc || full);
  assign dec_issue = dec_val && !dec_stall;

  assign kill   = rob_spec_resolve_result == RESOLVE_KILL;
  assign ins_en = dec_issue && dec_dst_en;

  // Clears first, issue set last so the issue wins on the same register.
  always_comb begin
    pend_d = pend_q;
    tag_d  = tag_q;
    for (int r = 1; r < NREGS; r++) begin
      if (kill && tag_q[r] == rob_spec_resolve_slot) pend_d[r] = 1'b0;
    end
    if (rob_commit_wen && pend_q[rob_commit_rf_waddr] &&
        tag_q[rob_commit_rf_waddr] == rob_commit_slot) begin
      pend_d[rob_commit_rf_waddr] = 1'b0;
    end
    if (ins_en && dec_dst != '0) begin
      pend_d[dec_dst] = 1'b1;
      tag_d[dec_dst]  = rob_alloc_resp_slot;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= '0;
      for (int r = 0; r < NREGS; r++) tag_q[r] <= '0;
    end else begin
      pend_q <= pend_d;
      tag_q  <= tag_d;
    end
  end

  parc_core_wb_window u_window (
    .clk        (clk),
    .reset      (reset),
    .ins_en     (ins_en),
    .ins_idx    (dec_lat),
    .ins_slot   (rob_alloc_resp_slot),
    .ins_waddr  (dec_dst),
    .kill_en    (kill),
    .kill_slot  (rob_spec_resolve_slot),
    .head_v     (rob_fill_val),
    .head_slot  (rob_fill_slot),
    .head_waddr (wb_waddr),
    .occ_v      (occ_v)
  );
endmodule
